// File: rtl/sequencer_sync.sv
// Gate Array master sequencer: 8-stage Johnson counter on cen_16.
// Build option: define SEQ_SELFCORRECT_EN to recover from illegal states.
`timescale 1ns/1ps

module sequencer_sync (
    input  logic       clk,
    input  logic       RESET,
    input  logic       cen_16,
    output logic [7:0] S,
    output logic       PHI_N,
    output logic       CCLK,
    output logic       RAS_N,
    output logic       WAIT_N,
    output logic       VIDEO_LOAD,
    output logic       CEN_4,
    output logic       CEN_1
);

    logic [7:0] s_q;
    logic [7:0] s_d;
    logic [3:0] k_q;
    logic [3:0] k_d;
    logic       vld_q;
    logic       vld_d;

    // Map a phase vector to its index; anything off-sequence reads as k=0.
    function automatic logic [4:0] decode_k(input logic [7:0] s);
        logic [4:0] r;
        r = 5'h00;
        case (s)
            8'h00: r = {1'b1, 4'd0};
            8'h01: r = {1'b1, 4'd1};
            8'h03: r = {1'b1, 4'd2};
            8'h07: r = {1'b1, 4'd3};
            8'h0F: r = {1'b1, 4'd4};
            8'h1F: r = {1'b1, 4'd5};
            8'h3F: r = {1'b1, 4'd6};
            8'h7F: r = {1'b1, 4'd7};
            8'hFF: r = {1'b1, 4'd8};
            8'hFE: r = {1'b1, 4'd9};
            8'hFC: r = {1'b1, 4'd10};
            8'hF8: r = {1'b1, 4'd11};
            8'hF0: r = {1'b1, 4'd12};
            8'hE0: r = {1'b1, 4'd13};
            8'hC0: r = {1'b1, 4'd14};
            8'h80: r = {1'b1, 4'd15};
            default: r = 5'h00;
        endcase
        return r;
    endfunction

    assign S = s_q;

    // Phase of the state currently held, used for the enable pulses.
    always_comb begin
        {vld_q, k_q} = decode_k(s_q);
    end

    // Next phase vector: Johnson shift on each enable.
    always_comb begin
        s_d = s_q;
        if (cen_16) begin
`ifdef SEQ_SELFCORRECT_EN
            if (vld_q) s_d = {s_q[6:0], ~s_q[7]};
            else       s_d = 8'h01;
`else
            s_d = {s_q[6:0], ~s_q[7]};
`endif
        end
    end

    // Phase of the next state, so strobes line up with S on the same edge.
    always_comb begin
        {vld_d, k_d} = decode_k(s_d);
    end

    // Phase register and strobes decoded from the next phase.
    always_ff @(posedge clk) begin
        if (RESET) begin
            s_q        <= 8'h00;
            PHI_N      <= 1'b1;
            CCLK       <= 1'b0;
            RAS_N      <= 1'b1;
            WAIT_N     <= 1'b0;
            VIDEO_LOAD <= 1'b0;
        end else begin
            s_q        <= s_d;
            PHI_N      <= ~k_d[1];
            CCLK       <= k_d[3];
            RAS_N      <= ~((k_d[2:0] >= 3'd2) && (k_d[2:0] <= 3'd6));
            WAIT_N     <= k_d[3] & k_d[2];
            VIDEO_LOAD <= (k_d == 4'd8);
        end
    end

    // Enable pulses fire in the cycle whose edge raises PHI_N / wraps to k=0.
    always_comb begin
        CEN_4 = cen_16 & (k_q[1:0] == 2'd3);
        CEN_1 = cen_16 & (k_q == 4'd15);
    end

    logic unused_vld;
    assign unused_vld = vld_d;

endmodule

// File: tb/tb_sequencer_sync.sv
// Self-checking bench for sequencer_sync.
// Phase-index reference model plus constant table and directed corners.
`timescale 1ns/1ps

module tb_sequencer_sync;

    logic       clk = 1'b0;
    logic       RESET = 1'b0;
    logic       cen_16 = 1'b0;
    logic [7:0] S;
    logic       PHI_N, CCLK, RAS_N, WAIT_N, VIDEO_LOAD, CEN_4, CEN_1;

    sequencer_sync dut (
        .clk(clk), .RESET(RESET), .cen_16(cen_16), .S(S),
        .PHI_N(PHI_N), .CCLK(CCLK), .RAS_N(RAS_N), .WAIT_N(WAIT_N),
        .VIDEO_LOAD(VIDEO_LOAD), .CEN_4(CEN_4), .CEN_1(CEN_1)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         k;
        logic [7:0] s;
        logic       phi, cclk, ras, wt, vl;
    } vec_t;

    vec_t tbl[16];
    int   checks = 0;
    int   errors = 0;
    int   mk = 0;
    bit   synced = 0;
    int   n_cen1 = 0;
    int   n_cen4 = 0;

    task automatic chk(input string n, input logic [7:0] got, input logic [7:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h exp %h (k=%0d t=%0t)", n, got, exp, mk, $time);
        end
    endtask

    function automatic logic [7:0] m_s(input int k);
        if (k <= 8) return 8'(((1 << k) - 1));
        return 8'((255 << (k - 8)) & 255);
    endfunction

    task automatic check_model();
        chk("S", S, m_s(mk));
        chk("PHI_N", PHI_N, 8'((mk % 4) < 2));
        chk("CCLK", CCLK, 8'(mk >= 8));
        chk("RAS_N", RAS_N,
            8'(!((mk >= 2 && mk <= 6) || (mk >= 10 && mk <= 14))));
        chk("WAIT_N", WAIT_N, 8'(mk >= 12));
        chk("VIDEO_LOAD", VIDEO_LOAD, 8'(mk == 8));
    endtask

    task automatic check_tbl();
        chk("tbl_S", S, tbl[mk].s);
        chk("tbl_PHI_N", PHI_N, tbl[mk].phi);
        chk("tbl_CCLK", CCLK, tbl[mk].cclk);
        chk("tbl_RAS_N", RAS_N, tbl[mk].ras);
        chk("tbl_WAIT_N", WAIT_N, tbl[mk].wt);
        chk("tbl_VL", VIDEO_LOAD, tbl[mk].vl);
    endtask

    task automatic cycle(input logic c, input logic r);
        @(negedge clk);
        cen_16 = c;
        RESET = r;
        #1;
        if (synced) begin
            chk("CEN_4", CEN_4, 8'(c && (mk % 4 == 3)));
            chk("CEN_1", CEN_1, 8'(c && (mk == 15)));
        end
        if (CEN_1 === 1'b1) n_cen1++;
        if (CEN_4 === 1'b1) n_cen4++;
        @(posedge clk);
        if (r) begin
            mk = 0;
            synced = 1;
        end else if (c && synced) begin
            mk = (mk + 1) % 16;
        end
        #1;
        if (synced) check_model();
    endtask

    logic [7:0] exp1, exp2;
    int c1, c4;

    initial begin
        tbl[0]  = '{0,  8'h00, 1, 0, 1, 0, 0};
        tbl[1]  = '{1,  8'h01, 1, 0, 1, 0, 0};
        tbl[2]  = '{2,  8'h03, 0, 0, 0, 0, 0};
        tbl[3]  = '{3,  8'h07, 0, 0, 0, 0, 0};
        tbl[4]  = '{4,  8'h0F, 1, 0, 0, 0, 0};
        tbl[5]  = '{5,  8'h1F, 1, 0, 0, 0, 0};
        tbl[6]  = '{6,  8'h3F, 0, 0, 0, 0, 0};
        tbl[7]  = '{7,  8'h7F, 0, 0, 1, 0, 0};
        tbl[8]  = '{8,  8'hFF, 1, 1, 1, 0, 1};
        tbl[9]  = '{9,  8'hFE, 1, 1, 1, 0, 0};
        tbl[10] = '{10, 8'hFC, 0, 1, 0, 0, 0};
        tbl[11] = '{11, 8'hF8, 0, 1, 0, 0, 0};
        tbl[12] = '{12, 8'hF0, 1, 1, 0, 1, 0};
        tbl[13] = '{13, 8'hE0, 1, 1, 0, 1, 0};
        tbl[14] = '{14, 8'hC0, 0, 1, 0, 1, 0};
        tbl[15] = '{15, 8'h80, 0, 1, 1, 1, 0};

        // Reset state
        cycle(1'b1, 1'b1);
        chk("rst_S", S, 8'h00);
        chk("rst_PHI_N", PHI_N, 8'h01);
        chk("rst_CCLK", CCLK, 8'h00);
        chk("rst_RAS_N", RAS_N, 8'h01);
        chk("rst_WAIT_N", WAIT_N, 8'h00);
        chk("rst_VL", VIDEO_LOAD, 8'h00);
        cycle(1'b0, 1'b0);

        // 32 pulses spaced 4 clk, table check after every pulse
        n_cen1 = 0;
        for (int p = 0; p < 32; p++) begin
            cycle(1'b1, 1'b0);
            check_tbl();
            for (int j = 0; j < 3; j++) cycle(1'b0, 1'b0);
        end
        chk("cen1_count32", 8'(n_cen1), 8'd2);
        chk("end32_S", S, 8'h00);

        // Freeze at k=5
        cycle(1'b0, 1'b1);
        for (int p = 0; p < 5; p++) cycle(1'b1, 1'b0);
        for (int p = 0; p < 50; p++) cycle(1'b0, 1'b0);
        chk("hold_S", S, 8'h1F);
        chk("hold_PHI_N", PHI_N, 8'h01);
        chk("hold_RAS_N", RAS_N, 8'h00);
        chk("hold_WAIT_N", WAIT_N, 8'h00);

        // Reset at k=11 with cen_16 high
        cycle(1'b0, 1'b1);
        for (int p = 0; p < 11; p++) cycle(1'b1, 1'b0);
        chk("k11_S", S, 8'hF8);
        n_cen1 = 0;
        cycle(1'b1, 1'b1);
        chk("rst11_S", S, 8'h00);
        chk("rst11_RAS_N", RAS_N, 8'h01);
        chk("rst11_WAIT_N", WAIT_N, 8'h00);
        chk("rst11_CCLK", CCLK, 8'h00);
        cycle(1'b0, 1'b0);
        chk("rst11_nocen1", 8'(n_cen1), 8'd0);

        // Illegal state injection
`ifdef SEQ_SELFCORRECT_EN
        exp1 = 8'h01;
        exp2 = 8'h03;
`else
        exp1 = 8'hB5;
        exp2 = 8'h6A;
`endif
        synced = 0;
        @(negedge clk);
        cen_16 = 1'b0;
        RESET = 1'b0;
        force dut.s_q = 8'h5A;
        @(posedge clk);
        #1;
        chk("forced_S", S, 8'h5A);
        @(negedge clk);
        release dut.s_q;
        #1;
        chk("illegal_CEN_4", CEN_4, 8'h00);
        cycle(1'b1, 1'b0);
        chk("fix_S", S, exp1);
        chk("fix_PHI_N", PHI_N, 8'h01);
        chk("fix_CCLK", CCLK, 8'h00);
        chk("fix_RAS_N", RAS_N, 8'h01);
        chk("fix_WAIT_N", WAIT_N, 8'h00);
        cycle(1'b1, 1'b0);
        chk("fix2_S", S, exp2);
        cycle(1'b0, 1'b1);

        // Back-to-back enables: full period in 16 clk
        c1 = n_cen1;
        c4 = n_cen4;
        for (int p = 0; p < 16; p++) cycle(1'b1, 1'b0);
        chk("b2b_S", S, 8'h00);
        chk("b2b_cen4", 8'(n_cen4 - c4), 8'd4);
        chk("b2b_cen1", 8'(n_cen1 - c1), 8'd1);

        // Random stimulus against the phase model
        for (int p = 0; p < 3000; p++) begin
            cycle(1'($urandom_range(0, 1)), 1'($urandom_range(0, 49) == 0));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/sequencer_sync.md
# sequencer_sync

Gate Array master sequencer: an 8-stage Johnson counter clocked by the 16 MHz enable. It produces the phase vector S[7:0], which `casgen_sync` and the video/RAM logic consume, and it derives the CPU clock, CRTC clock, RAS and WAIT strobes from that vector. It sits directly upstream of CAS generation, and every DRAM and CPU timing decision in the Gate Array keys off its outputs.

## Interface
- No parameters.
- clk  in  1  system clock; all state updates on posedge.
- RESET  in  1  synchronous, active-high reset (one clock, synchronous active-high reset).
- cen_16  in  1  16 MHz clock enable, one clk wide.
- S  out  8  Johnson phase vector, registered.
- PHI_N  out  1  inverted 4 MHz CPU clock, registered.
- CCLK  out  1  1 MHz CRTC clock, registered.
- RAS_N  out  1  DRAM row strobe, registered.
- WAIT_N  out  1  Z80 wait, low = wait, registered.
- VIDEO_LOAD  out  1  video byte latch strobe, registered.
- CEN_4  out  1  combinational one-clk pulse, asserted in the clk cycle whose edge raises PHI_N.
- CEN_1  out  1  combinational one-clk pulse, asserted in the clk cycle whose edge wraps the sequence to k=0.

## Operation
- Shift rule on cen_16: S <= {S[6:0], ~S[7]}.
- Phase index k (0..15) is the count of valid Johnson states from 8'h00:
  - k=0..8: S = 00, 01, 03, 07, 0F, 1F, 3F, 7F, FF.
  - k=9..15: S = FE, FC, F8, F0, E0, C0, 80.
- Sequence period is 16 cen_16 = 1 µs.
- Derived outputs are decoded from the next S value. They are registered on the same edge as S, so outputs always match the k currently held in S.
- PHI_N = 1 when k mod 4 ∈ {0,1}; 0 when k mod 4 ∈ {2,3}.
- CCLK = 1 when k ∈ 8..15; equivalently CCLK = S[7].
- RAS_N = 0 when k ∈ 2..6 or k ∈ 10..14; 1 otherwise. This gives two memory cycles per µs: video, then CPU.
- WAIT_N = 1 when k ∈ 12..15; 0 otherwise. This aligns every CPU memory access to a 1 µs boundary.
- VIDEO_LOAD = 1 while k = 8, i.e. one full cen_16 interval.
- CEN_4 = cen_16 & (k mod 4 == 3).
- CEN_1 = cen_16 & (k == 15).
- When cen_16 = 0, all registers hold.

## Timing
- Reset (RESET=1 at an edge; takes priority over cen_16):
  - S=8'h00 (k=0), PHI_N=1, CCLK=0, RAS_N=1, WAIT_N=0, VIDEO_LOAD=0.
  - CEN_4 and CEN_1 evaluate to 0 because k=0.
- First cen_16 after reset release moves to k=1. Latency from cen_16 to output change is one clk.
- Reset asserted mid-sequence forces k=0 on that edge regardless of phase. No partial strobes follow.
- CEN_1 occurs exactly once per 16 cen_16. CEN_4 occurs exactly once per 4 cen_16.
- If cen_16 is high in consecutive clks, the counter advances every clk. Nothing is skipped or merged.

## Configuration
- SEQ_SELFCORRECT_EN defined:
  - Any S not among the 16 valid Johnson states is replaced on the next cen_16 edge by 8'h01 (k=1).
  - Derived outputs are decoded from 8'h01.
  - Recovery takes at most one cen_16.
- SEQ_SELFCORRECT_EN undefined:
  - The plain shift rule applies to all states.
  - An illegal state circulates indefinitely.
  - Derived outputs are decoded by the same k-decode logic, and invalid patterns decode to k=0 values.

## Test plan
- Reset, then 32 cen_16 pulses (spaced 4 clk) -> S steps 00,01,03,…,FF,FE,…,80,00 twice; CEN_1 pulses exactly twice, in the clk before each S=00 edge.
- Same run -> PHI_N pattern 1,1,0,0 per 4 steps; CCLK = S[7]; RAS_N low only at k 2–6 and 10–14; WAIT_N high only at k 12–15; VIDEO_LOAD high only at k=8.
- Hold cen_16=0 for 50 clk at k=5 -> all outputs frozen at S=1F, PHI_N=1, RAS_N=0, WAIT_N=0.
- Assert RESET at k=11 with cen_16 high in the same clk -> next S=00, RAS_N=1, WAIT_N=0, CCLK=0; no CEN_1 pulse.
- With SEQ_SELFCORRECT_EN defined, force S=8'h5A, release, give one cen_16 -> S=01, PHI_N=1, then the normal sequence resumes. Without the macro, the same stimulus gives S=B5.
- cen_16 tied high for 16 clk -> full period in 16 clk; CEN_4 pulses four times.
